// File: rtl/sb_tx_msg_fifo_pkg.sv
`default_nettype none
// ============================================================================
// sb_tx_pkg : shared types and sizes for the sideband TX message buffer
// Rev 1.0
// ============================================================================
package sb_tx_pkg;

   localparam int SB_WORD_W        = 64;
   localparam int SB_TX_FIFO_DEPTH = 8;

   typedef logic [SB_WORD_W-1:0] sb_word_t;

   typedef struct packed {
      sb_word_t hdr;
      sb_word_t data;
      logic     has_data;
   } sb_msg_t;

   // Number of 64-bit words a message occupies in the buffer.
   function automatic logic [1:0] sb_msg_words(input logic has_data);
      return has_data ? 2'd2 : 2'd1;
   endfunction

endpackage : sb_tx_pkg
`default_nettype wire

// File: rtl/sb_tx_msg_fifo_if.sv
`default_nettype none
// ============================================================================
// sb_tx_msg_fifo_if : controller write side and serializer read side bundle
// Rev 1.0
// ============================================================================
interface sb_tx_msg_fifo_if #(
   parameter int W = sb_tx_pkg::SB_WORD_W
);

   logic         wr_valid;
   logic         wr_ready;
   logic [W-1:0] wr_hdr;
   logic [W-1:0] wr_data;
   logic         wr_has_data;
   logic [W-1:0] tx_data;
   logic         tx_enable;
   logic         tx_pop;

   // master = controller + serializer side, slave = the buffer itself
   modport master (
      output wr_valid, wr_hdr, wr_data, wr_has_data, tx_pop,
      input  wr_ready, tx_data, tx_enable
   );

   modport slave (
      input  wr_valid, wr_hdr, wr_data, wr_has_data, tx_pop,
      output wr_ready, tx_data, tx_enable
   );

endinterface : sb_tx_msg_fifo_if
`default_nettype wire

// File: rtl/sb_tx_msg_fifo_mem.sv
`default_nettype none
// ============================================================================
// sb_tx_fifo_mem : DEPTH x W register array, dual adjacent write, async read
// Rev 1.0
// ============================================================================
module sb_tx_fifo_mem
   import sb_tx_pkg::*;
#(
   parameter int DEPTH = SB_TX_FIFO_DEPTH,
   parameter int W     = SB_WORD_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic          clk,
   input  wire logic          i_we0,
   input  wire logic [AW-1:0] i_waddr,
   input  wire logic [W-1:0]  i_wdata0,
   input  wire logic          i_we1,
   input  wire logic [W-1:0]  i_wdata1,
   input  wire logic [AW-1:0] i_raddr,
   output      logic [W-1:0]  o_rdata
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] w_waddr1;

   // Second port lands on the next slot; AW-bit arithmetic wraps DEPTH-1 -> 0.
   assign w_waddr1 = i_waddr + AW'(1);

   always_ff @(posedge clk) begin
      if (i_we0) begin
         r_mem[i_waddr] <= i_wdata0;
      end
      if (i_we1) begin
         r_mem[w_waddr1] <= i_wdata1;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : sb_tx_fifo_mem
`default_nettype wire

// File: rtl/sb_tx_msg_fifo.sv
`default_nettype none
// ============================================================================
// sb_tx_msg_fifo : atomic-message FWFT word buffer feeding the SB serializer
// Rev 1.0
// ============================================================================
module sb_tx_msg_fifo
   import sb_tx_pkg::*;
#(
   parameter int DEPTH = SB_TX_FIFO_DEPTH,
   parameter int W     = SB_WORD_W
) (
   input  wire logic                 pll_clk,
   input  wire logic                 rst,
   sb_tx_msg_fifo_if.slave           bus,
   input  wire logic                 err_clr,
   output      logic [$clog2(DEPTH):0] count,
   output      logic                 overflow_err,
   output      logic                 underflow_err
);

   localparam int              c_AW        = $clog2(DEPTH);
   localparam int              c_CW        = c_AW + 1;
   localparam logic [c_CW-1:0] c_READY_MAX = c_CW'(DEPTH - 2);

   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_CW-1:0] r_count;
   logic            r_overflow;
   logic            r_underflow;

   logic            w_wr_ready;
   logic            w_tx_enable;
   logic            w_wr_acc;
   logic            w_pop_acc;
   logic            w_ovf_set;
   logic            w_unf_set;
   logic [c_CW-1:0] w_n_wr;
   logic [c_CW-1:0] w_n_pop;
   logic [c_CW-1:0] w_count_next;
   logic [W-1:0]    w_head;

   // Ready needs two free slots regardless of message size, so it depends
   // only on the registered count and never on this cycle's inputs.
   assign w_wr_ready  = (r_count <= c_READY_MAX);
   assign w_tx_enable = (r_count != '0);

   assign w_wr_acc  = bus.wr_valid & w_wr_ready;
   assign w_pop_acc = bus.tx_pop & w_tx_enable;
   assign w_ovf_set = bus.wr_valid & ~w_wr_ready;
   assign w_unf_set = bus.tx_pop & ~w_tx_enable;

   always_comb begin
      w_n_wr = '0;
      if (w_wr_acc) begin
         w_n_wr = c_CW'(sb_msg_words(bus.wr_has_data));
      end
   end

   assign w_n_pop      = {{c_AW{1'b0}}, w_pop_acc};
   assign w_count_next = r_count + w_n_wr - w_n_pop;

   always_ff @(posedge pll_clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_n_wr[c_AW-1:0];
         if (w_pop_acc) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         r_count <= w_count_next;
      end
   end

   // A set event in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge pll_clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_set) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   sb_tx_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (W),
      .AW    (c_AW)
   ) u_mem (
      .clk      (pll_clk),
      .i_we0    (w_wr_acc),
      .i_waddr  (r_wr_ptr),
      .i_wdata0 (bus.wr_hdr),
      .i_we1    (w_wr_acc & bus.wr_has_data),
      .i_wdata1 (bus.wr_data),
      .i_raddr  (r_rd_ptr),
      .o_rdata  (w_head)
   );

   assign bus.tx_data     = w_tx_enable ? w_head : '0;
   assign bus.tx_enable   = w_tx_enable;
   assign bus.wr_ready    = w_wr_ready;
   assign count           = r_count;
   assign overflow_err    = r_overflow;
   assign underflow_err   = r_underflow;

endmodule : sb_tx_msg_fifo
`default_nettype wire

// File: tb/tb_sb_tx_msg_fifo.sv
`default_nettype none
// ============================================================================
// tb_sb_tx_msg_fifo : directed + random stimulus against a word-queue model
// Rev 1.0
// ============================================================================
module tb_sb_tx_msg_fifo;
   import sb_tx_pkg::*;

   localparam int DEPTH = 8;

   logic       pll_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       err_clr = 1'b0;
   logic [3:0] count;
   logic       overflow_err;
   logic       underflow_err;

   sb_tx_msg_fifo_if #(.W(64)) bus ();

   sb_tx_msg_fifo #(.DEPTH(DEPTH), .W(64)) dut (
      .pll_clk       (pll_clk),
      .rst           (rst),
      .bus           (bus),
      .err_clr       (err_clr),
      .count         (count),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   always #5 pll_clk = ~pll_clk;

   int       checks   = 0;
   int       failures = 0;
   bit       done     = 1'b0;
   sb_word_t exp_q[$];
   int       pop_pending = 0;
   logic     exp_ovf = 1'b0;
   logic     exp_unf = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of words. Acceptance is judged on the occupancy
   // before this edge's pop, which the monitor already removed at negedge.
   always @(posedge pll_clk) begin
      int  occ;
      bit  ovf_set;
      bit  unf_set;
      occ = exp_q.size() + pop_pending;
      if (rst) begin
         exp_q.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         ovf_set = bus.wr_valid && ((DEPTH - occ) < 2);
         unf_set = bus.tx_pop && (occ == 0);
         if (bus.wr_valid && !ovf_set) begin
            exp_q.push_back(bus.wr_hdr);
            if (bus.wr_has_data) exp_q.push_back(bus.wr_data);
         end
         exp_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : exp_ovf);
         exp_unf = unf_set ? 1'b1 : (err_clr ? 1'b0 : exp_unf);
      end
      pop_pending = 0;
   end

   // Monitor: compare visible state, pop the expected word when it is consumed.
   always @(negedge pll_clk) begin
      if (!done) begin
         check("count", 64'(count), 64'(exp_q.size()));
         check("tx_enable", 64'(bus.tx_enable), 64'(exp_q.size() > 0));
         check("wr_ready", 64'(bus.wr_ready), 64'((DEPTH - exp_q.size()) >= 2));
         check("overflow_err", 64'(overflow_err), 64'(exp_ovf));
         check("underflow_err", 64'(underflow_err), 64'(exp_unf));
         if (exp_q.size() > 0) check("tx_data", bus.tx_data, exp_q[0]);
         else                  check("tx_data_empty", bus.tx_data, 64'h0);
         if (!rst && bus.tx_pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            pop_pending = 1;
         end
      end
   end

   task automatic step();
      @(posedge pll_clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_valid    = 1'b0;
      bus.wr_has_data = 1'b0;
      bus.tx_pop      = 1'b0;
      err_clr         = 1'b0;
   endtask

   task automatic wr(input sb_word_t h, input sb_word_t d, input bit hd, input bit pop_too);
      bus.wr_valid    = 1'b1;
      bus.wr_hdr      = h;
      bus.wr_data     = d;
      bus.wr_has_data = hd;
      bus.tx_pop      = pop_too;
      step();
      idle();
   endtask

   task automatic pop_n(input int n);
      for (int k = 0; k < n; k++) begin
         bus.tx_pop = 1'b1;
         step();
      end
      bus.tx_pop = 1'b0;
   endtask

   initial begin
      idle();
      bus.wr_hdr  = '0;
      bus.wr_data = '0;
      rst = 1'b1;
      repeat (4) step();
      rst = 1'b0;
      step();

      // Header-only, then two-word message with a zero data phase
      wr(64'hA5A5A5A5A5A5A5A5, 64'hDEAD, 1'b0, 1'b0);
      step();
      pop_n(1);
      wr(64'hB4B4B4B4B4B4B4B4, 64'h0, 1'b1, 1'b0);
      pop_n(2);
      pop_n(1);

      // Fill to 7 words, overflow attempt, then clear
      for (int m = 0; m < 3; m++) wr(64'h100 + 64'(m), 64'h200 + 64'(m), 1'b1, 1'b0);
      wr(64'h333, 64'h0, 1'b0, 1'b0);
      wr(64'hBAD, 64'hBAD, 1'b0, 1'b0);
      step();
      err_clr = 1'b1;
      step();
      idle();
      pop_n(7);

      // Walk pointers to 7 (currently at 2), then a wrapping 2-word message
      for (int m = 0; m < 5; m++) wr(64'h500 + 64'(m), 64'h0, 1'b0, 1'b0);
      pop_n(5);
      wr(64'h1, 64'h2, 1'b1, 1'b0);
      pop_n(2);
      wr(64'h77, 64'h0, 1'b0, 1'b0);
      wr(64'h88, 64'h99, 1'b1, 1'b1);
      pop_n(3);

      // Underflow, then reset with 5 words stored
      pop_n(1);
      step();
      for (int m = 0; m < 2; m++) wr(64'h600 + 64'(m), 64'h700 + 64'(m), 1'b1, 1'b0);
      wr(64'h650, 64'h0, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      // Randomized traffic with phases of differing write pressure
      for (int i = 0; i < 3000; i++) begin
         int wr_pct;
         wr_pct = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 45 : 70);
         bus.wr_valid    = ($urandom_range(0, 99) < wr_pct);
         bus.wr_has_data = $urandom_range(0, 1) == 1;
         bus.wr_hdr      = {$urandom, $urandom};
         bus.wr_data     = {$urandom, $urandom};
         bus.tx_pop      = ($urandom_range(0, 99) < 45);
         err_clr         = ($urandom_range(0, 19) == 0);
         rst             = ($urandom_range(0, 299) == 0);
         step();
      end
      idle();
      rst = 1'b0;
      repeat (2) step();
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sb_tx_msg_fifo
`default_nettype wire
